branch_predictor: RTL

//  Fetch-side counterpart to the EX-stage branch resolver: predicts direction and target for the IF-stage PC.

---
 rtl/branch_predictor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : branch_predictor
// Brief   : Direct-mapped BTB with 2-bit direction counters, misprediction
//           detection against the EX-stage resolution, and saturating stats.
// Revision: 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [31:0]      fetch_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_BITS-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0]    fetch_tag, upd_tag;
    logic                fetch_hit, upd_hit, upd_en;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

    // Lookup reads only the registered table, so a same-cycle update is not bypassed.
    always_comb begin
        fetch_idx   = fetch_pc[IDX_BITS+1:2];
        fetch_tag   = fetch_pc[31:IDX_BITS+2];
        fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
        pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;
    end

    always_comb begin
        upd_en      = enable && upd_valid;
        upd_idx     = upd_pc[IDX_BITS+1:2];
        upd_tag     = upd_pc[31:IDX_BITS+2];
        upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        mispredict  = upd_en && ((upd_taken != upd_pred_taken) ||
                      (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_en) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = upd_taken ? sat_inc(ctr_q[upd_idx]) : sat_dec(ctr_q[upd_idx]);
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                end
            end else if (upd_taken) begin
                // Taken miss replaces whatever alias is resident.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = CTR_WT;
            end
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
        end
        if (mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= CTR_WNT;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
`default_nettype wire
